branch_predictor_bht: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage pipeline. Decodes a B-type

---
 rtl/branch_predictor_bht.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: PC-indexed table of 2-bit saturating counters,
// a bounded FIFO of in-flight predictions, and resolve/train/redirect logic.
module branch_predictor_bht #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] CNT_INIT    = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  StallF,
    input  logic                  BranchE,
    input  logic                  ZeroE,
    input  logic                  JumpE,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  flushBranch,
    output logic                  QueueFull,
    output logic                  ErrFlag
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    logic [1:0]            r_cnt    [BHT_ENTRIES];
    logic [DATA_WIDTH-1:0] r_qPc    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_qTgt   [QUEUE_DEPTH];
    logic                  r_qPred  [QUEUE_DEPTH];
    logic [IDX_W-1:0]      r_qIdx   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_errFlag;

    logic                  w_isBr;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_tgt;
    logic                  w_pred;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_mispredict;
    logic                  w_push;
    logic                  w_accept;
    logic                  w_clear;
    logic [IDX_W-1:0]      w_headIdx;
    logic [DATA_WIDTH-1:0] w_headPc;
    logic [DATA_WIDTH-1:0] w_headTgt;
    logic                  w_headPred;
    logic [1:0]            w_headCnt;
    logic [1:0]            w_trainCnt;
    logic                  w_unusedBits;

    // Fetch-side decode: B-type detection, counter index, and branch target
    assign w_isBr = (RD[6:0] == 7'b1100011);
    assign w_idx  = PCF[IDX_W+1:2];
    assign w_imm  = {{(DATA_WIDTH-13){RD[31]}}, RD[31], RD[7], RD[30:25], RD[11:8], 1'b0};
    assign w_tgt  = PCF + w_imm;
    assign w_pred = r_cnt[w_idx][1];
    assign w_unusedBits = ^RD[24:12];

    // Head-of-FIFO view and the resolve decision
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_COUNT);
    assign w_headIdx    = r_qIdx[r_head];
    assign w_headPc     = r_qPc[r_head];
    assign w_headTgt    = r_qTgt[r_head];
    assign w_headPred   = r_qPred[r_head];
    assign w_pop        = BranchE && !w_empty;
    assign w_mispredict = w_pop && (w_headPred != ZeroE);
    assign w_clear      = w_mispredict || JumpE;
    assign w_push       = w_isBr && !StallF && !w_mispredict && !JumpE;
    assign w_accept     = w_push && (!w_full || w_pop);

    // Saturating update of the head entry's counter toward the real outcome
    assign w_headCnt  = r_cnt[w_headIdx];
    assign w_trainCnt = ZeroE ? ((w_headCnt == 2'b11) ? 2'b11 : w_headCnt + 2'b01)
                              : ((w_headCnt == 2'b00) ? 2'b00 : w_headCnt - 2'b01);

    assign QueueFull = w_full;
    assign ErrFlag   = r_errFlag;

    // Redirect selection: a mispredict recovery wins over the Fetch prediction
    always_comb begin
        PCBPUSrc    = 1'b0;
        PCBPU       = '0;
        flushBranch = 1'b0;
        if (w_mispredict) begin
            PCBPUSrc    = 1'b1;
            flushBranch = 1'b1;
            PCBPU       = ZeroE ? w_headTgt : (w_headPc + DATA_WIDTH'(4));
        end else if (w_isBr && w_pred) begin
            PCBPUSrc = 1'b1;
            PCBPU    = w_tgt;
        end
    end

    // Counter table: train on each resolve; Fetch reads the pre-update value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
        end else if (w_pop) begin
            r_cnt[w_headIdx] <= w_trainCnt;
        end
    end

    // FIFO payload storage, written at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_qPc[i]   <= '0;
                r_qTgt[i]  <= '0;
                r_qPred[i] <= 1'b0;
                r_qIdx[i]  <= '0;
            end
        end else if (w_accept) begin
            r_qPc[r_tail]   <= PCF;
            r_qTgt[r_tail]  <= w_tgt;
            r_qPred[r_tail] <= w_pred;
            r_qIdx[r_tail]  <= w_idx;
        end
    end

    // FIFO pointers and occupancy; a mispredict or jump drops all younger entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_accept) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    // Sticky error: overflowing push or resolve against an empty FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errFlag <= 1'b0;
        end else if ((w_push && w_full && !w_pop) || (BranchE && w_empty)) begin
            r_errFlag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_branch_predictor_bht;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BEQ16  = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] LOOPM8 = 32'hFE00_0CE3;  // beq x0,x0,-8

    logic        clk;
    logic        rst_n;
    logic [31:0] RD;
    logic [31:0] PCF;
    logic        StallF;
    logic        BranchE;
    logic        ZeroE;
    logic        JumpE;
    logic [31:0] PCBPU;
    logic        PCBPUSrc;
    logic        flushBranch;
    logic        QueueFull;
    logic        ErrFlag;

    branch_predictor_bht dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RD          (RD),
        .PCF         (PCF),
        .StallF      (StallF),
        .BranchE     (BranchE),
        .ZeroE       (ZeroE),
        .JumpE       (JumpE),
        .PCBPU       (PCBPU),
        .PCBPUSrc    (PCBPUSrc),
        .flushBranch (flushBranch),
        .QueueFull   (QueueFull),
        .ErrFlag     (ErrFlag)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          pred;
        int          idx;
    } entry_t;

    entry_t mq[$];
    int     mcnt[16];
    bit     merr;
    int     nChecks = 0;
    int     nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic resetModel();
        for (int i = 0; i < 16; i++) mcnt[i] = 2;
        mq.delete();
        merr = 0;
    endtask

    function automatic logic [31:0] branchTarget(input logic [31:0] rd, input logic [31:0] pc);
        int imm;
        imm = (rd[31] ? -4096 : 0) + int'(rd[7]) * 2048 + int'(rd[30:25]) * 32 + int'(rd[11:8]) * 2;
        return pc + imm;
    endfunction

    // Compare DUT outputs against the model for the inputs now applied
    task automatic checkOutput();
        bit          isBr;
        bit          pred;
        bit          misp;
        bit          expSrc;
        bit          expFlush;
        logic [31:0] expPc;
        isBr     = (RD[6:0] == 7'h63);
        pred     = (mcnt[(PCF >> 2) % 16] >= 2);
        misp     = BranchE && (mq.size() > 0) && (mq[0].pred != ZeroE);
        expSrc   = 0;
        expFlush = 0;
        expPc    = 0;
        if (misp) begin
            expSrc   = 1;
            expFlush = 1;
            expPc    = ZeroE ? mq[0].tgt : mq[0].pc + 32'd4;
        end else if (isBr && pred) begin
            expSrc = 1;
            expPc  = branchTarget(RD, PCF);
        end
        check("PCBPUSrc", {31'b0, PCBPUSrc}, {31'b0, expSrc});
        check("flushBranch", {31'b0, flushBranch}, {31'b0, expFlush});
        check("QueueFull", {31'b0, QueueFull}, {31'b0, mq.size() == 4});
        check("ErrFlag", {31'b0, ErrFlag}, {31'b0, merr});
        if (expSrc || (mq.size() == 0 && !isBr)) check("PCBPU", PCBPU, expPc);
    endtask

    // Advance the model by one rising edge using the applied inputs
    task automatic updateModel();
        bit     isBr;
        bit     pred;
        bit     misp;
        bit     push;
        int     idx;
        entry_t h;
        entry_t e;
        isBr = (RD[6:0] == 7'h63);
        idx  = (PCF >> 2) % 16;
        pred = (mcnt[idx] >= 2);
        misp = 0;
        if (BranchE && mq.size() == 0) merr = 1;
        if (BranchE && mq.size() > 0) begin
            h    = mq.pop_front();
            misp = (h.pred != ZeroE);
            if (ZeroE) mcnt[h.idx] = (mcnt[h.idx] < 3) ? mcnt[h.idx] + 1 : 3;
            else       mcnt[h.idx] = (mcnt[h.idx] > 0) ? mcnt[h.idx] - 1 : 0;
        end
        push = isBr && !StallF && !misp && !JumpE;
        if (misp || JumpE) begin
            mq.delete();
        end else if (push) begin
            if (mq.size() < 4) begin
                e.pc   = PCF;
                e.tgt  = branchTarget(RD, PCF);
                e.pred = pred;
                e.idx  = idx;
                mq.push_back(e);
            end else begin
                merr = 1;
            end
        end
    endtask

    // Drive one cycle of inputs after the falling edge, check, and step the model
    task automatic applyStimulus(input logic [31:0] rd, input logic [31:0] pcf, input logic stall,
                                 input logic br, input logic zero, input logic jump);
        @(negedge clk);
        RD      = rd;
        PCF     = pcf;
        StallF  = stall;
        BranchE = br;
        ZeroE   = zero;
        JumpE   = jump;
        #1;
        checkOutput();
        updateModel();
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic resetMid();
        @(negedge clk);
        #2;
        RD      = NOP;
        BranchE = 1'b0;
        JumpE   = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst ErrFlag", {31'b0, ErrFlag}, 32'd0);
        check("rst QueueFull", {31'b0, QueueFull}, 32'd0);
        check("rst PCBPUSrc", {31'b0, PCBPUSrc}, 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pcf;
        rst_n   = 1'b0;
        RD      = NOP;
        PCF     = '0;
        StallF  = 1'b0;
        BranchE = 1'b0;
        ZeroE   = 1'b0;
        JumpE   = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        check("lit reset PCBPUSrc", {31'b0, PCBPUSrc}, 32'd0);
        check("lit reset ErrFlag", {31'b0, ErrFlag}, 32'd0);

        applyStimulus(BEQ16, 32'h40, 0, 0, 0, 0);
        check("lit t1 PCBPUSrc", {31'b0, PCBPUSrc}, 32'd1);
        check("lit t1 PCBPU", PCBPU, 32'h50);

        applyStimulus(NOP, 32'h44, 0, 1, 0, 0);
        check("lit t2 flush", {31'b0, flushBranch}, 32'd1);
        check("lit t2 PCBPU", PCBPU, 32'h44);
        applyStimulus(BEQ16, 32'h40, 1, 0, 0, 0);
        check("lit t2 refetch PCBPUSrc", {31'b0, PCBPUSrc}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(LOOPM8, 32'h20, 0, 0, 0, 0);
            check("lit t3 loop PCBPU", PCBPU, 32'h18);
            applyStimulus(NOP, 32'h24, 0, 1, 1, 0);
            check("lit t3 no flush", {31'b0, flushBranch}, 32'd0);
        end
        applyStimulus(LOOPM8, 32'h24, 0, 0, 0, 0);
        check("lit t3 0x24 PCBPU", PCBPU, 32'h1C);
        applyStimulus(NOP, 32'h28, 0, 1, 0, 0);
        check("lit t3 0x24 redirect", PCBPU, 32'h28);
        applyStimulus(LOOPM8, 32'h20, 1, 0, 0, 0);
        check("lit t3 0x20 still taken", {31'b0, PCBPUSrc}, 32'd1);
        applyStimulus(LOOPM8, 32'h24, 1, 0, 0, 0);
        check("lit t3 0x24 not taken", {31'b0, PCBPUSrc}, 32'd0);

        for (int i = 0; i < 4; i++) applyStimulus(BEQ16, 32'h130 + 32'(4 * i), 0, 0, 0, 0);
        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        check("lit t4 full", {31'b0, QueueFull}, 32'd1);
        applyStimulus(BEQ16, 32'h140, 0, 0, 0, 0);
        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        check("lit t4 overflow ErrFlag", {31'b0, ErrFlag}, 32'd1);
        applyStimulus(BEQ16, 32'h144, 0, 1, 1, 0);
        check("lit t4 pushpop PCBPU", PCBPU, 32'h154);
        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        check("lit t4 still full", {31'b0, QueueFull}, 32'd1);

        resetMid();

        applyStimulus(BEQ16, 32'h200, 0, 0, 0, 0);
        applyStimulus(BEQ16, 32'h204, 0, 0, 0, 0);
        applyStimulus(BEQ16, 32'h208, 0, 1, 0, 0);
        check("lit t5 flush", {31'b0, flushBranch}, 32'd1);
        check("lit t5 PCBPU", PCBPU, 32'h204);
        applyStimulus(NOP, 32'h0, 0, 1, 0, 0);
        check("lit t5 empty no flush", {31'b0, flushBranch}, 32'd0);
        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        check("lit t6 empty ErrFlag", {31'b0, ErrFlag}, 32'd1);

        applyStimulus(BEQ16, 32'h310, 0, 0, 0, 0);
        applyStimulus(BEQ16, 32'h314, 0, 0, 0, 0);
        applyStimulus(NOP, 32'h0, 0, 0, 0, 1);
        applyStimulus(NOP, 32'h0, 0, 1, 0, 0);
        check("lit t6 jump cleared", {31'b0, flushBranch}, 32'd0);

        resetMid();

        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) resetMid();
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom();
                rd[6:0] = 7'h63;
            end else begin
                rd = $urandom();
                if (rd[6:0] == 7'h63) rd[0] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) pcf = $urandom() & 32'hFFFF_FFFC;
            else pcf = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            applyStimulus(rd, pcf, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
